uart_cmd_ctrl: RTL and testbench

Command controller that sequences the shared UART FIFO interface. It pops received bytes, parses short ASCII commands, and updates the board LEDs, RGB LED and baud divisor register. It answers each command with a one-byte status pushed into the TX FIFO. It sits between `uart` (FIFO side) and the top-level pins, replacing the constant `rd_uart`/`wr_uart` tie-offs and the hard-wired divisor.

---
 rtl/uart_cmd_pkg.sv | 36 +++
 rtl/uart_cmd_timeout.sv | 40 ++++
 rtl/uart_cmd_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Opcodes, reply bytes and the hex-digit decode helper live here.
package uart_cmd_pkg;

    localparam int DVSR_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_EXEC,
        ST_REPLY
    } cmd_state_t;

    localparam logic [7:0] ASCII_L   = 8'h4C;
    localparam logic [7:0] ASCII_C   = 8'h43;
    localparam logic [7:0] ASCII_D   = 8'h44;
    localparam logic [7:0] ASCII_ACK = 8'h4B;
    localparam logic [7:0] ASCII_NAK = 8'h3F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    // Returns {valid, value} for '0'-'9', 'A'-'F', 'a'-'f'.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) ||
                     (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout for a partially received command.
// Down-counter reloads on clr, saturates at zero, expired at zero.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 12_500_000,
    localparam int W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on clear, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register; reset corresponds to a freshly cleared count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command controller between the UART FIFOs and the board pins.
// Parses L/C/D commands and answers each with one status byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [DVSR_W-1:0] DVSR_DEFAULT   = 11'd68,
    parameter int                TIMEOUT_CYCLES = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [DVSR_W-1:0] dvsr,
    output logic [3:0]        led,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
);

    cmd_state_t        state_q;
    logic [7:0]        op_q;
    logic [7:0]        arg1_q;
    logic [7:0]        arg2_q;
    logic [7:0]        w_data_q;
    logic [3:0]        led_q;
    logic [2:0]        rgb_q;
    logic [DVSR_W-1:0] dvsr_q;

    logic              in_arg;
    logic              expired;
    logic [4:0]        nib;
    logic [DVSR_W-1:0] dvsr_new;

    assign in_arg   = (state_q == ST_ARG1) || (state_q == ST_ARG2);
    assign rd_uart  = (in_arg || state_q == ST_IDLE) && !rx_empty;
    assign wr_uart  = (state_q == ST_REPLY) && !tx_full;
    assign nib      = hex_to_nibble(arg1_q);
    assign dvsr_new = {arg1_q[2:0], arg2_q};

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (rd_uart),
        .en     (in_arg && rx_empty),
        .expired(expired)
    );

    // Command FSM with registered reply byte and board outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            arg1_q   <= '0;
            arg2_q   <= '0;
            w_data_q <= '0;
            led_q    <= '0;
            rgb_q    <= '0;
            dvsr_q   <= DVSR_DEFAULT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        if (r_data == ASCII_L || r_data == ASCII_C ||
                            r_data == ASCII_D) begin
                            op_q    <= r_data;
                            state_q <= ST_ARG1;
                        end else if (r_data != ASCII_CR &&
                                     r_data != ASCII_LF) begin
                            w_data_q <= ASCII_NAK;
                            state_q  <= ST_REPLY;
                        end
                    end
                end
                ST_ARG1: begin
                    if (!rx_empty) begin
                        arg1_q  <= r_data;
                        state_q <= (op_q == ASCII_D) ? ST_ARG2 : ST_EXEC;
                    end else if (expired) begin
                        w_data_q <= ASCII_NAK;
                        state_q  <= ST_REPLY;
                    end
                end
                ST_ARG2: begin
                    if (!rx_empty) begin
                        arg2_q  <= r_data;
                        state_q <= ST_EXEC;
                    end else if (expired) begin
                        w_data_q <= ASCII_NAK;
                        state_q  <= ST_REPLY;
                    end
                end
                ST_EXEC: begin
                    w_data_q <= ASCII_NAK;
                    state_q  <= ST_REPLY;
                    if (op_q == ASCII_L && nib[4]) begin
                        led_q    <= nib[3:0];
                        w_data_q <= ASCII_ACK;
                    end else if (op_q == ASCII_C && arg1_q >= 8'h30 &&
                                 arg1_q <= 8'h37) begin
                        rgb_q    <= arg1_q[2:0];
                        w_data_q <= ASCII_ACK;
                    end else if (op_q == ASCII_D && dvsr_new != '0) begin
                        dvsr_q   <= dvsr_new;
                        w_data_q <= ASCII_ACK;
                    end
                end
                ST_REPLY: begin
                    if (!tx_full) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_data = w_data_q;
    assign led    = led_q;
    assign dvsr   = dvsr_q;
    assign led_r  = rgb_q[2];
    assign led_g  = rgb_q[1];
    assign led_b  = rgb_q[0];

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with modelled RX/TX FIFOs.
// Uses a 16-cycle timeout so expiry cases stay short.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic [10:0] dvsr;
    logic [3:0]  led;
    logic        led_r;
    logic        led_g;
    logic        led_b;

    int n_vec = 0;
    int n_err = 0;
    int pops = 0;
    int pushes = 0;
    int p0;
    int s0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       rd_seen;
    logic       wr_seen;
    logic [7:0] wd_seen;

    uart_cmd_ctrl #(
        .DVSR_DEFAULT  (11'd68),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_empty(rx_empty),
        .r_data  (r_data),
        .rd_uart (rd_uart),
        .tx_full (tx_full),
        .w_data  (w_data),
        .wr_uart (wr_uart),
        .dvsr    (dvsr),
        .led     (led),
        .led_r   (led_r),
        .led_g   (led_g),
        .led_b   (led_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_refresh();
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic rx_put(input logic [7:0] b);
        rxq.push_back(b);
        rx_refresh();
    endtask

    function automatic logic [7:0] tx_last();
        return (txq.size() == 0) ? 8'h00 : txq[txq.size()-1];
    endfunction

    // Sample strobes just before the rising edge.
    always @(negedge clk) begin
        #4;
        rd_seen = rd_uart;
        wr_seen = wr_uart;
        wd_seen = w_data;
    end

    // Apply the FIFO effects of that edge just after it.
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            pops++;
            if (rxq.size() != 0) void'(rxq.pop_front());
            rx_refresh();
        end
        if (wr_seen) begin
            pushes++;
            txq.push_back(wd_seen);
        end
    end

    initial begin
        reset   = 1'b1;
        tx_full = 1'b0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        wd_seen = 8'h00;
        rx_refresh();
        repeat (2) @(negedge clk);
        chk("rst_dvsr", 32'(dvsr), 32'd68);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_rgb", 32'({led_r, led_g, led_b}), 32'h0);
        chk("rst_wdata", 32'(w_data), 32'h0);
        chk("rst_wr", 32'(wr_uart), 32'h0);
        chk("rst_rd", 32'(rd_uart), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        rx_put(8'h4C);
        rx_put(8'h41);
        repeat (2) @(negedge clk);
        chk("lat_led_pre", 32'(led), 32'h0);
        chk("lat_wr_pre", 32'(wr_uart), 32'h0);
        @(negedge clk);
        chk("lat_led", 32'(led), 32'hA);
        chk("lat_wr", 32'(wr_uart), 32'h1);
        repeat (4) @(negedge clk);
        chk("la_pops", 32'(pops), 32'd2);
        chk("la_pushes", 32'(pushes), 32'd1);
        chk("la_reply", 32'(tx_last()), 32'h4B);

        rx_put(8'h43);
        rx_put(8'h35);
        repeat (8) @(negedge clk);
        chk("c5_rgb", 32'({led_r, led_g, led_b}), 32'h5);
        chk("c5_reply", 32'(tx_last()), 32'h4B);
        rx_put(8'h4C);
        rx_put(8'h67);
        repeat (8) @(negedge clk);
        chk("lg_led", 32'(led), 32'hA);
        chk("lg_reply", 32'(tx_last()), 32'h3F);
        chk("lg_pushes", 32'(pushes), 32'd3);

        rx_put(8'h44);
        rx_put(8'h01);
        rx_put(8'h0F);
        repeat (8) @(negedge clk);
        chk("d10f_dvsr", 32'(dvsr), 32'h10F);
        chk("d10f_reply", 32'(tx_last()), 32'h4B);
        rx_put(8'h0D);
        rx_put(8'h44);
        rx_put(8'h00);
        rx_put(8'h00);
        repeat (8) @(negedge clk);
        chk("d0_dvsr", 32'(dvsr), 32'h10F);
        chk("d0_reply", 32'(tx_last()), 32'h3F);
        chk("d0_pushes", 32'(pushes), 32'd5);

        p0 = pops;
        s0 = pushes;
        tx_full = 1'b1;
        rx_put(8'h4C);
        rx_put(8'h33);
        rx_put(8'h4C);
        rx_put(8'h35);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("hold_wdata", 32'(w_data), 32'h4B);
            @(negedge clk);
        end
        chk("hold_pops", 32'(pops - p0), 32'd2);
        chk("hold_pushes", 32'(pushes - s0), 32'd0);
        chk("hold_led", 32'(led), 32'h3);
        tx_full = 1'b0;
        repeat (8) @(negedge clk);
        chk("rel_pushes", 32'(pushes - s0), 32'd2);
        chk("rel_pops", 32'(pops - p0), 32'd4);
        chk("rel_led", 32'(led), 32'h5);

        s0 = pushes;
        rx_put(8'h4C);
        repeat (16) @(negedge clk);
        chk("to_wr_pre", 32'(wr_uart), 32'h0);
        @(negedge clk);
        chk("to_wr", 32'(wr_uart), 32'h1);
        chk("to_wdata", 32'(w_data), 32'h3F);
        repeat (2) @(negedge clk);
        chk("to_pushes", 32'(pushes - s0), 32'd1);
        chk("to_led", 32'(led), 32'h5);

        s0 = pushes;
        rx_put(8'h4C);
        repeat (16) @(negedge clk);
        rx_put(8'h37);
        repeat (4) @(negedge clk);
        chk("tor_led", 32'(led), 32'h7);
        chk("tor_pushes", 32'(pushes - s0), 32'd1);
        chk("tor_reply", 32'(tx_last()), 32'h4B);

        s0 = pushes;
        rx_put(8'h44);
        rx_put(8'h02);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_dvsr", 32'(dvsr), 32'd68);
        chk("mid_led", 32'(led), 32'h0);
        chk("mid_rgb", 32'({led_r, led_g, led_b}), 32'h0);
        chk("mid_wdata", 32'(w_data), 32'h0);
        chk("mid_wr", 32'(wr_uart), 32'h0);
        reset = 1'b0;
        repeat (24) @(negedge clk);
        chk("mid_pushes", 32'(pushes - s0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
